// File: rtl/fp_addsub_pkg.sv
// Shared constants and FSM state type for the FP adder/subtractor normaliser.
package fp_addsub_pkg;

    localparam int MAN_W   = 23;
    localparam int EXP_W   = 9;
    localparam int EXP_MAX = 255;

    // Field positions inside the raw significand sum {C,H,F,G,St}
    localparam int C_BIT  = 26;
    localparam int H_BIT  = 25;
    localparam int G_BIT  = 1;
    localparam int ST_BIT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fp_norm_lzc.sv
// 26-bit leading-zero counter for the single-cycle normalise path.
// Only compiled when FP_NORM_LZC_EN is defined; the iterative build carries no LZC.
`ifdef FP_NORM_LZC_EN
module fp_norm_lzc (
    input  logic [25:0] din,
    output logic [4:0]  cnt
);

    // Ascending scan so the most significant set bit is the last to write cnt
    always_comb begin
        cnt = 5'd26;
        for (int i = 0; i < 26; i++) begin
            if (din[i]) cnt = 5'(25 - i);
        end
    end

endmodule
`endif

// File: rtl/fp_addsub_norm_seq.sv
// Sequential post-add normaliser: raw significand sum + exponent in, NormE/NormM/R/S out.
// FP_NORM_LZC_EN selects a single-cycle LZC-driven left shift instead of 1 bit/cycle.
module fp_addsub_norm_seq #(
    parameter int MAN_W   = fp_addsub_pkg::MAN_W,
    parameter int EXP_W   = fp_addsub_pkg::EXP_W,
    parameter int EXP_MAX = fp_addsub_pkg::EXP_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sgn,
    input  logic [1:0]       in_rmode,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W+3:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sgn,
    output logic [1:0]       out_rmode,
    output logic [EXP_W-1:0] out_e,
    output logic [MAN_W-1:0] out_m,
    output logic             out_r,
    output logic             out_s,
    output logic             out_zero,
    output logic             out_ovf
);

    import fp_addsub_pkg::*;

    localparam int SUM_W = MAN_W + 4;

    state_t             state, next_state;
    logic [SUM_W-1:0]   mr, mr_next;
    logic [EXP_W-1:0]   er, er_next;
    logic               zero, zero_next;
    logic               sgn, sgn_next;
    logic [1:0]         rmode, rmode_next;

`ifdef FP_NORM_LZC_EN
    logic [4:0]         lzc_cnt;
    logic [EXP_W-1:0]   lzc_ext, er_m1, shamt;
    logic [SUM_W-1:0]   mr_shl;

    fp_norm_lzc u_lzc (
        .din (mr[SUM_W-2:0]),
        .cnt (lzc_cnt)
    );

    // Never shift further than the exponent allows; the remainder becomes subnormal
    always_comb begin
        lzc_ext = {{(EXP_W-5){1'b0}}, lzc_cnt};
        er_m1   = er - EXP_W'(1);
        shamt   = (lzc_ext < er_m1) ? lzc_ext : er_m1;
        mr_shl  = mr << shamt;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mr    <= '0;
            er    <= '0;
            zero  <= 1'b0;
            sgn   <= 1'b0;
            rmode <= 2'b00;
        end else begin
            state <= next_state;
            mr    <= mr_next;
            er    <= er_next;
            zero  <= zero_next;
            sgn   <= sgn_next;
            rmode <= rmode_next;
        end
    end

    always_comb begin
        next_state = state;
        mr_next    = mr;
        er_next    = er;
        zero_next  = zero;
        sgn_next   = sgn;
        rmode_next = rmode;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    mr_next    = in_sum;
                    // A zero exponent (subnormal operand) has an effective exponent of 1
                    er_next    = (in_exp == '0) ? EXP_W'(1) : in_exp;
                    zero_next  = 1'b0;
                    sgn_next   = in_sgn;
                    rmode_next = in_rmode;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (mr == '0) begin
                    er_next    = '0;
                    zero_next  = 1'b1;
                    next_state = DONE;
                end else if (mr[C_BIT]) begin
                    // Carry out: right shift one, folding the dropped bit into sticky
                    mr_next    = {1'b0, mr[SUM_W-1:2], mr[G_BIT] | mr[ST_BIT]};
                    er_next    = er + EXP_W'(1);
                    next_state = DONE;
`ifdef FP_NORM_LZC_EN
                end else begin
                    mr_next    = mr_shl;
                    er_next    = mr_shl[H_BIT] ? (er - shamt) : '0;
                    next_state = DONE;
                end
`else
                end else if (mr[H_BIT] || (er <= EXP_W'(1))) begin
                    if (!mr[H_BIT]) er_next = '0;
                    next_state = DONE;
                end else begin
                    mr_next = {mr[SUM_W-2:0], 1'b0};
                    er_next = er - EXP_W'(1);
                end
`endif
            end
            DONE: begin
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_sgn   = sgn;
    assign out_rmode = rmode;
    assign out_e     = er;
    assign out_m     = mr[SUM_W-3:2];
    assign out_r     = mr[G_BIT];
    assign out_s     = mr[ST_BIT];
    assign out_zero  = zero;
    assign out_ovf   = (er >= EXP_W'(EXP_MAX));

endmodule
